// File: rtl/ram_arbiter_if.sv
// Bundles the CPU, VGA and single-port RAM signals around the arbiter.
// Latency: none, this is wiring only. Backpressure: cpu_stall and vga_gnt are carried here, not generated here.
// slave is the arbiter view and master is the requester/RAM view.
interface ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vga_req, vga_addr,
        input  ram_rdata,
        output cpu_stall, cpu_rdata,
        output vga_gnt, vga_rvalid, vga_rdata,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vga_req, vga_addr,
        output ram_rdata,
        input  cpu_stall, cpu_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between a CPU (default priority) and a VGA reader with an anti-starvation forced grant.
// Latency: the grant and the ram_* outputs are combinational; read data returns one cycle after the grant.
// Backpressure: cpu_stall holds the CPU, vga_req is held until vga_gnt. Optional stall_count output is under RAM_ARB_STATS_EN.
module ram_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]  stall_count
`endif
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        VGA_RD = 2'd2
    } owner_e;

    owner_e            state;
    owner_e            state_nxt;
    logic [7:0]        wait_cnt;
    logic              vga_sel;
    logic              cpu_sel;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ram_addr_int;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_int;
    logic              vga_rvalid_int;

    // Selection is gated by reset so the grant-side outputs drop as soon as reset asserts.
    always_comb begin
        vga_sel = reset && bus.vga_req && (!bus.cpu_req || (wait_cnt >= MAX_WAIT_C));
        cpu_sel = reset && bus.cpu_req && !vga_sel;
    end

    always_comb begin
        if (vga_sel) begin
            ram_addr_int = bus.vga_addr;
        end else if (cpu_sel) begin
            ram_addr_int = bus.cpu_addr;
        end else begin
            ram_addr_int = addr_q;
        end
    end

    assign bus.ram_addr  = ram_addr_int;
    assign bus.ram_we    = cpu_sel && bus.cpu_we;
    assign bus.ram_wdata = bus.cpu_wdata;
    assign bus.vga_gnt   = vga_sel;
    assign bus.cpu_stall = reset && bus.cpu_req && vga_sel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
            addr_q   <= '0;
        end else begin
            addr_q <= ram_addr_int;
            if (bus.vga_req && !vga_sel) begin
                wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    // Owner FSM: remembers who issued the read that the RAM returns this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (vga_sel) begin
            state_nxt = VGA_RD;
        end else if (cpu_sel && !bus.cpu_we) begin
            state_nxt = CPU_RD;
        end
    end

    always_comb begin
        vga_rvalid_int = 1'b0;
        cpu_rdata_int  = cpu_rdata_q;
        case (state)
            CPU_RD:  cpu_rdata_int  = bus.ram_rdata;
            VGA_RD:  vga_rvalid_int = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
        end else begin
            cpu_rdata_q <= cpu_rdata_int;
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_int;
    assign bus.vga_rvalid = vga_rvalid_int;
    assign bus.vga_rdata  = bus.ram_rdata;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (bus.cpu_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a cycle-level reference model and a RAM model attached to the RAM port.
// Build with RAM_ARB_STATS_EN defined to also exercise stall_count.
module tb_ram_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stall_count;
`endif

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM attached to the arbiter, and an independent golden image used by the model.
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] m_mem   [0:(1<<ADDR_W)-1];

    always @(posedge clock) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: owner 0 = no read pending, 1 = CPU read, 2 = VGA read.
    int                m_wait, n_wait;
    int                m_owner, n_owner;
    logic [ADDR_W-1:0] m_rd_addr, n_rd_addr;
    logic [ADDR_W-1:0] m_last_addr;
    logic [DATA_W-1:0] m_cpu_rdata;
    int                m_stalls;
    logic              vwin, e_stall, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    initial begin : model
        m_wait = 0; m_owner = 0; m_rd_addr = '0; m_last_addr = '0;
        m_cpu_rdata = '0; m_stalls = 0;
        n_wait = 0; n_owner = 0; n_rd_addr = '0;
        vwin = 1'b0; e_stall = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_gnt", 64'(bus.vga_gnt), 64'(0));
                chk("rst_stall", 64'(bus.cpu_stall), 64'(0));
                chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
                chk("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
                chk("rst_rvalid", 64'(bus.vga_rvalid), 64'(0));
                chk("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
                vwin = 1'b0; e_stall = 1'b0; e_we = 1'b0;
            end else begin
                vwin    = bus.vga_req && (!bus.cpu_req || m_wait >= MAX_WAIT);
                e_stall = bus.cpu_req && vwin;
                e_we    = bus.cpu_req && !vwin && bus.cpu_we;
                e_addr  = vwin ? bus.vga_addr : (bus.cpu_req ? bus.cpu_addr : m_last_addr);
                e_wdata = bus.cpu_wdata;
                chk("gnt", 64'(bus.vga_gnt), 64'(vwin));
                chk("stall", 64'(bus.cpu_stall), 64'(e_stall));
                chk("ram_we", 64'(bus.ram_we), 64'(e_we));
                chk("ram_addr", 64'(bus.ram_addr), 64'(e_addr));
                if (e_we) chk("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdata));
                chk("rvalid", 64'(bus.vga_rvalid), 64'(m_owner == 2));
                if (m_owner == 2) chk("vga_rdata", 64'(bus.vga_rdata), 64'(m_mem[m_rd_addr]));
                if (m_owner == 1) m_cpu_rdata = m_mem[m_rd_addr];
                chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(m_cpu_rdata));
`ifdef RAM_ARB_STATS_EN
                chk("stall_count", 64'(stall_count), 64'(m_stalls));
`endif
                n_wait    = (bus.vga_req && !vwin) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
                n_owner   = vwin ? 2 : ((bus.cpu_req && !bus.cpu_we) ? 1 : 0);
                n_rd_addr = e_addr;
            end
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_wait = 0; m_owner = 0; m_last_addr = '0; m_cpu_rdata = '0; m_stalls = 0;
            end else begin
                if (e_we) m_mem[e_addr] = e_wdata;
                if (e_stall && m_stalls < 65535) m_stalls = m_stalls + 1;
                m_wait = n_wait; m_owner = n_owner; m_rd_addr = n_rd_addr; m_last_addr = e_addr;
            end
        end
    end

    task automatic drive(input logic creq, input logic cwe, input logic [ADDR_W-1:0] caddr,
                         input logic [DATA_W-1:0] cwdata, input logic vreq,
                         input logic [ADDR_W-1:0] vaddr);
        @(posedge clock);
        #1;
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwdata;
        bus.vga_req = vreq; bus.vga_addr = vaddr;
    endtask

    task automatic starve(input string nm, input logic [ADDR_W-1:0] vaddr);
        int gk;
        gk = 0;
        drive(1'b1, 1'b0, 12'h030, 32'h0, 1'b1, vaddr);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) chk({nm, "_simul_no_stall"}, 64'(bus.cpu_stall), 64'(0));
            if (bus.vga_gnt) begin
                gk = k;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk({nm, "_grant_cycle"}, 64'(gk), 64'(9));
        chk({nm, "_stall_at_grant"}, 64'(bus.cpu_stall), 64'(1));
        drive(1'b1, 1'b0, 12'h030, 32'h0, 1'b0, vaddr);
        @(negedge clock);
        chk({nm, "_stall_one_cycle"}, 64'(bus.cpu_stall), 64'(0));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        n_total = 0; n_pass = 0;
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        ram_mem[12'h020] = 32'h12345678;
        m_mem[12'h020]   = 32'h12345678;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ram_addr", 64'(bus.ram_addr), 64'(0));
        chk("reset_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));

        // First cycle after reset: VGA-only read of 0x020.
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.vga_req = 1'b1; bus.vga_addr = 12'h020;
        @(negedge clock);
        chk("first_gnt", 64'(bus.vga_gnt), 64'(1));
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h020);
        @(negedge clock);
        chk("vga_rvalid_lit", 64'(bus.vga_rvalid), 64'(1));
        chk("vga_rdata_lit", 64'(bus.vga_rdata), 64'(32'h12345678));

        // CPU-only write then read back.
        drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 12'h000);
        @(negedge clock);
        chk("cpu_wr_no_stall", 64'(bus.cpu_stall), 64'(0));
        drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 12'h000);
        @(negedge clock);
        chk("cpu_rd_no_stall", 64'(bus.cpu_stall), 64'(0));
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        @(negedge clock);
        chk("cpu_rdata_lit", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        @(negedge clock);
        chk("cpu_rdata_hold", 64'(bus.cpu_rdata), 64'(32'hDEADBEEF));

        starve("starve1", 12'h020);

        // Forced grant lands on a CPU write; the write must follow one cycle later.
        drive(1'b1, 1'b0, 12'h030, 32'h0, 1'b1, 12'h024);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("cont_wait_no_gnt", 64'(bus.vga_gnt), 64'(0));
            @(posedge clock);
            #1;
        end
        bus.cpu_we = 1'b1; bus.cpu_addr = 12'h040; bus.cpu_wdata = 32'hAAAA5555;
        @(negedge clock);
        chk("cont_gnt", 64'(bus.vga_gnt), 64'(1));
        chk("cont_we_blocked", 64'(bus.ram_we), 64'(0));
        drive(1'b1, 1'b1, 12'h040, 32'hAAAA5555, 1'b0, 12'h024);
        @(negedge clock);
        chk("cont_we_lands", 64'(bus.ram_we), 64'(1));
        chk("cont_we_addr", 64'(bus.ram_addr), 64'(12'h040));
        drive(1'b1, 1'b0, 12'h040, 32'h0, 1'b0, 12'h024);
        @(negedge clock);
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        @(negedge clock);
        chk("cont_readback", 64'(bus.cpu_rdata), 64'(32'hAAAA5555));

        starve("starve3", 12'h020);
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
        @(negedge clock);
`ifdef RAM_ARB_STATS_EN
        chk("stall_count_lit", 64'(stall_count), 64'(3));
`endif

        // Reset while a VGA read is in flight.
        drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h020);
        @(negedge clock);
        chk("mid_gnt", 64'(bus.vga_gnt), 64'(1));
        #1;
        reset = 1'b0;
        bus.vga_req = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(bus.vga_rvalid), 64'(0));
        chk("mid_rst_gnt", 64'(bus.vga_gnt), 64'(0));
        chk("mid_rst_ram_addr", 64'(bus.ram_addr), 64'(0));
        chk("mid_rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
        chk("mid_rst_ram_we", 64'(bus.ram_we), 64'(0));
        chk("mid_rst_stall", 64'(bus.cpu_stall), 64'(0));
`ifdef RAM_ARB_STATS_EN
        chk("mid_rst_stall_count", 64'(stall_count), 64'(0));
`endif
        @(posedge clock);
        #1;
        chk("mid_rst_edge_rvalid", 64'(bus.vga_rvalid), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_no_rvalid", 64'(bus.vga_rvalid), 64'(0));
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
